pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer_return_stack.sv | 40 ++++
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared opcode and FSM state definitions for the program-counter sequencer
// and its controller.
package pc_sequencer_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BZ   = 3'd2,
        OP_BNZ  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } state_e;

    // The unassigned eighth code behaves as a plain sequential step
    function automatic op_e decode_op(input logic [OP_W-1:0] raw);
        return (raw == 3'd7) ? OP_SEQ : op_e'(raw);
    endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: controller-to-sequencer bundle; master is the controller side,
// slave is the sequencer.
interface pc_sequencer_if #(parameter int PC_W = 12);
    logic            stall;
    logic [2:0]      op;
    logic [PC_W-1:0] target;
    logic            zero;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic            fetch_en;
    logic            halted;
    logic            fault;
    logic            ovf;
    logic            unf;

    modport master (
        output stall, op, target, zero, resume,
        input  pc, fetch_en, halted, fault, ovf, unf
    );

    modport slave (
        input  stall, op, target, zero, resume,
        output pc, fetch_en, halted, fault, ovf, unf
    );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: LIFO of return addresses with full/empty status.
// Entries are not reset; only the pointer is, so stale data is unreachable.
module return_stack #(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_data,
    output logic [PC_W-1:0] o_data,
    output logic            o_full,
    output logic            o_empty
);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [PC_W-1:0] r_mem [STACK_DEPTH];
    logic [AW:0]     r_sp;
    logic [AW-1:0]   w_top;

    assign o_full  = (r_sp == (AW+1)'(STACK_DEPTH));
    assign o_empty = (r_sp == '0);
    assign w_top   = r_sp[AW-1:0] - AW'(1);
    assign o_data  = r_mem[w_top];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sp <= '0;
        else if (i_push && !o_full)
            r_sp <= r_sp + (AW+1)'(1);
        else if (i_pop && !o_empty)
            r_sp <= r_sp - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_sp[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with branches, call/return stack,
// halt/resume and a reset-only fault state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 8
) (
    input logic         clk,
    input logic         rst,
    pc_sequencer_if.slave bus
);
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_ret_pc;
    state_e          r_state;
    state_e          w_state_nxt;
    op_e             w_op;
    logic            r_ovf;
    logic            r_unf;
    logic            w_ovf_set;
    logic            w_unf_set;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    return_stack #(
        .PC_W       (PC_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (w_pc_inc),
        .o_data (w_ret_pc),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_comb begin
        w_op        = decode_op(bus.op);
        w_pc_inc    = r_pc + PC_W'(1);
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (!bus.stall && r_state == ST_RUN) begin
            case (w_op)
                OP_JMP:  w_pc_nxt = bus.target;
                OP_BZ:   w_pc_nxt = bus.zero ? bus.target : w_pc_inc;
                OP_BNZ:  w_pc_nxt = bus.zero ? w_pc_inc : bus.target;
                OP_CALL: begin
                    w_push      = !w_full;
                    w_ovf_set   = w_full;
                    w_pc_nxt    = w_full ? r_pc : bus.target;
                    w_state_nxt = w_full ? ST_FAULT : ST_RUN;
                end
                OP_RET: begin
                    w_pop       = !w_empty;
                    w_unf_set   = w_empty;
                    w_pc_nxt    = w_empty ? r_pc : w_ret_pc;
                    w_state_nxt = w_empty ? ST_FAULT : ST_RUN;
                end
                OP_HALT: w_state_nxt = ST_HALTED;
                default: w_pc_nxt = w_pc_inc;
            endcase
        end else if (!bus.stall && r_state == ST_HALTED && bus.resume) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= '0;
            r_state <= ST_RUN;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.fetch_en = (r_state == ST_RUN) && !bus.stall;
    assign bus.halted   = (r_state == ST_HALTED);
    assign bus.fault    = (r_state == ST_FAULT);
    assign bus.ovf      = r_ovf;
    assign bus.unf      = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of sequencing, branches, call/return,
// stack overflow/underflow, wrap, halt/resume and async reset.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] o, input logic [11:0] t, input logic z);
        bus.op     = o;
        bus.target = t;
        bus.zero   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic async_rst();
        rst = 1'b0;
        #1;
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);
        chk("rst_unf", 32'(bus.unf), 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        bus.stall  = 1'b0;
        bus.resume = 1'b0;
        bus.op     = OP_SEQ;
        bus.target = '0;
        bus.zero   = 1'b0;
        #1;
        async_rst();
        chk("rst_fetch_en", 32'(bus.fetch_en), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            cyc(OP_SEQ, 12'h000, 1'b0);
            chk("seq_pc", 32'(bus.pc), 32'(k));
            chk("seq_fetch_en", 32'(bus.fetch_en), 32'h1);
        end
        cyc(OP_SEQ, 12'h000, 1'b0);
        chk("seq_pc5", 32'(bus.pc), 32'h5);
        cyc(OP_BZ, 12'h100, 1'b0);
        chk("bz_not_taken", 32'(bus.pc), 32'h6);
        cyc(OP_BZ, 12'h100, 1'b1);
        chk("bz_taken", 32'(bus.pc), 32'h100);
        cyc(OP_BNZ, 12'h080, 1'b1);
        chk("bnz_not_taken", 32'(bus.pc), 32'h101);
        cyc(OP_BNZ, 12'h080, 1'b0);
        chk("bnz_taken", 32'(bus.pc), 32'h080);
        cyc(3'd7, 12'h555, 1'b1);
        chk("op7_as_seq", 32'(bus.pc), 32'h081);
        cyc(OP_JMP, 12'h010, 1'b0);
        chk("jmp", 32'(bus.pc), 32'h010);
        cyc(OP_CALL, 12'h200, 1'b0);
        chk("call1", 32'(bus.pc), 32'h200);
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(OP_CALL, 12'h300, 1'b0);
            chk("stall_pc", 32'(bus.pc), 32'h200);
            chk("stall_fetch_en", 32'(bus.fetch_en), 32'h0);
        end
        bus.stall = 1'b0;
        cyc(OP_CALL, 12'h300, 1'b0);
        chk("call2", 32'(bus.pc), 32'h300);
        cyc(OP_RET, 12'h000, 1'b0);
        chk("ret1", 32'(bus.pc), 32'h201);
        cyc(OP_RET, 12'h000, 1'b0);
        chk("ret2", 32'(bus.pc), 32'h011);
        bus.stall = 1'b1;
        cyc(OP_RET, 12'h000, 1'b0);
        chk("stall_ret_pc", 32'(bus.pc), 32'h011);
        chk("stall_ret_fault", 32'(bus.fault), 32'h0);
        chk("stall_ret_unf", 32'(bus.unf), 32'h0);
        bus.stall = 1'b0;
        async_rst();
        for (int k = 0; k < 8; k++) begin
            cyc(OP_CALL, 12'(12'h100 + k * 12'h010), 1'b0);
            chk("fill_pc", 32'(bus.pc), 32'(12'h100 + k * 12'h010));
        end
        chk("fill_ovf", 32'(bus.ovf), 32'h0);
        cyc(OP_CALL, 12'h3FF, 1'b0);
        chk("ovf_pc", 32'(bus.pc), 32'h170);
        chk("ovf_flag", 32'(bus.ovf), 32'h1);
        chk("ovf_fault", 32'(bus.fault), 32'h1);
        chk("ovf_fetch_en", 32'(bus.fetch_en), 32'h0);
        cyc(OP_RET, 12'h000, 1'b0);
        chk("fault_ret_pc", 32'(bus.pc), 32'h170);
        chk("fault_ret_unf", 32'(bus.unf), 32'h0);
        bus.resume = 1'b1;
        cyc(OP_JMP, 12'h222, 1'b0);
        chk("fault_resume_pc", 32'(bus.pc), 32'h170);
        chk("fault_resume_fault", 32'(bus.fault), 32'h1);
        bus.resume = 1'b0;
        async_rst();
        cyc(OP_RET, 12'h000, 1'b0);
        chk("unf_pc", 32'(bus.pc), 32'h0);
        chk("unf_flag", 32'(bus.unf), 32'h1);
        chk("unf_fault", 32'(bus.fault), 32'h1);
        async_rst();
        cyc(OP_JMP, 12'hFFF, 1'b0);
        chk("jmp_fff", 32'(bus.pc), 32'hFFF);
        cyc(OP_SEQ, 12'h000, 1'b0);
        chk("wrap_pc", 32'(bus.pc), 32'h000);
        chk("wrap_ovf", 32'(bus.ovf), 32'h0);
        chk("wrap_fault", 32'(bus.fault), 32'h0);
        cyc(OP_JMP, 12'h040, 1'b0);
        chk("jmp_040", 32'(bus.pc), 32'h040);
        cyc(OP_HALT, 12'h000, 1'b0);
        chk("halt_pc", 32'(bus.pc), 32'h040);
        chk("halt_flag", 32'(bus.halted), 32'h1);
        chk("halt_fetch_en", 32'(bus.fetch_en), 32'h0);
        cyc(OP_JMP, 12'h123, 1'b0);
        chk("halt_ignore_op", 32'(bus.pc), 32'h040);
        bus.stall  = 1'b1;
        bus.resume = 1'b1;
        cyc(OP_SEQ, 12'h000, 1'b0);
        chk("resume_stall_pc", 32'(bus.pc), 32'h040);
        chk("resume_stall_halted", 32'(bus.halted), 32'h1);
        bus.stall = 1'b0;
        cyc(OP_JMP, 12'h777, 1'b0);
        chk("resume_pc", 32'(bus.pc), 32'h041);
        chk("resume_halted", 32'(bus.halted), 32'h0);
        chk("resume_fetch_en", 32'(bus.fetch_en), 32'h1);
        bus.resume = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
